pll_vdp_supervisor: RTL and testbench

- Closes the loop around the VDP PLL (50 MHz ref to 100/25 MHz).
- Drives the PLL's active-high reset and watches its asynchronous locked output.
- Sequences reset release to the VDP clock consumers and re-initialises the PLL on lock loss, lock timeout or a software request.
- Sits in the refclk domain next to the PLL wrapper; downstream domains re-synchronise sys_reset_n themselves.

---
 rtl/pll_vdp_supervisor.sv | 172 +++++++++++++++++
 tb/tb_pll_vdp_supervisor.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_vdp_supervisor.sv
// pll_vdp_supervisor
// ------------------
// Supervises the VDP PLL from the 50 MHz reference clock domain. It holds the
// PLL in reset for a fixed pulse, waits for its locked output, qualifies lock
// stability, and then releases the VDP logic reset. The PLL is re-initialised
// on lock loss, on lock timeout, or on a software request.
//
// Ports:
//   refclk      - reference clock, the only clock of this block
//   rst_n       - asynchronous active-low reset
//   pll_locked  - raw PLL locked flag, asynchronous to refclk
//   relock_req  - single-cycle request to force a PLL re-initialisation
//   pll_rst     - active-high PLL reset (registered)
//   sys_reset_n - active-low VDP logic reset, high only in RUN (registered)
//   state       - 0=RESET_PLL, 1=WAIT_LOCK, 2=STABLE_CHECK, 3=RUN
//   lost_cnt    - saturating count of lock losses seen in RUN
//   tmo_cnt     - saturating count of lock timeouts
module pll_vdp_supervisor #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 50000,
   parameter int STABLE_CYCLES = 1024,
   parameter int CNT_W         = 8
) (
   input  logic             refclk,
   input  logic             rst_n,
   input  logic             pll_locked,
   input  logic             relock_req,
   output logic             pll_rst,
   output logic             sys_reset_n,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] lost_cnt,
   output logic [CNT_W-1:0] tmo_cnt
);

   // One extra bit of headroom so each timer can hold its terminal value + 1
   // on the cycle it leaves its state.
   localparam int RST_W = $clog2(RST_CYCLES + 1);
   localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);
   localparam int STB_W = $clog2(STABLE_CYCLES + 1);

   localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);
   localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      S_RESET_PLL    = 2'd0,
      S_WAIT_LOCK    = 2'd1,
      S_STABLE_CHECK = 2'd2,
      S_RUN          = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic               sync1_q, lk_s_q;
   logic [RST_W-1:0]   rst_tmr_q, rst_tmr_d;
   logic [TMO_W-1:0]   lock_tmr_q, lock_tmr_d;
   logic [STB_W-1:0]   stab_tmr_q, stab_tmr_d;
   logic               pll_rst_q, pll_rst_d;
   logic               sys_reset_n_q, sys_reset_n_d;
   logic [CNT_W-1:0]   lost_cnt_q, lost_cnt_d;
   logic [CNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
   logic               lost_inc, tmo_inc;

   // Next-state logic. The lock timeout is checked before the request and the
   // lock flag so that a timeout always gets counted, even when it coincides
   // with a relock request or with the final stable-check cycle.
   always_comb begin
      state_d    = state_q;
      rst_tmr_d  = rst_tmr_q;
      lock_tmr_d = lock_tmr_q;
      stab_tmr_d = stab_tmr_q;
      lost_inc   = 1'b0;
      tmo_inc    = 1'b0;

      case (state_q)
         S_RESET_PLL: begin
            if (rst_tmr_q == RST_LAST) begin
               state_d    = S_WAIT_LOCK;
               lock_tmr_d = '0;
            end else begin
               rst_tmr_d = rst_tmr_q + RST_W'(1);
            end
         end

         S_WAIT_LOCK: begin
            lock_tmr_d = lock_tmr_q + TMO_W'(1);
            if (lock_tmr_q == TMO_LAST) begin
               state_d = S_RESET_PLL;
               tmo_inc = 1'b1;
            end else if (relock_req) begin
               state_d = S_RESET_PLL;
            end else if (lk_s_q) begin
               state_d    = S_STABLE_CHECK;
               stab_tmr_d = '0;
            end
         end

         S_STABLE_CHECK: begin
            lock_tmr_d = lock_tmr_q + TMO_W'(1);
            stab_tmr_d = stab_tmr_q + STB_W'(1);
            if (lock_tmr_q == TMO_LAST) begin
               state_d = S_RESET_PLL;
               tmo_inc = 1'b1;
            end else if (relock_req) begin
               state_d = S_RESET_PLL;
            end else if (!lk_s_q) begin
               state_d = S_WAIT_LOCK;
            end else if (stab_tmr_q == STB_LAST) begin
               state_d = S_RUN;
            end
         end

         S_RUN: begin
            if (!lk_s_q) begin
               state_d  = S_RESET_PLL;
               lost_inc = 1'b1;
            end else if (relock_req) begin
               state_d = S_RESET_PLL;
            end
         end

         default: state_d = S_RESET_PLL;
      endcase

      // Every entry into RESET_PLL starts a fresh, full-length reset pulse.
      if ((state_d == S_RESET_PLL) && (state_q != S_RESET_PLL)) begin
         rst_tmr_d = '0;
      end

      lost_cnt_d = (lost_inc && (lost_cnt_q != CNT_MAX)) ? lost_cnt_q + CNT_W'(1) : lost_cnt_q;
      tmo_cnt_d  = (tmo_inc  && (tmo_cnt_q  != CNT_MAX)) ? tmo_cnt_q  + CNT_W'(1) : tmo_cnt_q;

      // Outputs are decoded from the next state so they change on the same
      // edge as the state itself.
      pll_rst_d     = (state_d == S_RESET_PLL);
      sys_reset_n_d = (state_d == S_RUN);
   end

   // Two-flop synchroniser for the asynchronous locked flag, plus all state.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q       <= 1'b0;
         lk_s_q        <= 1'b0;
         state_q       <= S_RESET_PLL;
         rst_tmr_q     <= '0;
         lock_tmr_q    <= '0;
         stab_tmr_q    <= '0;
         pll_rst_q     <= 1'b1;
         sys_reset_n_q <= 1'b0;
         lost_cnt_q    <= '0;
         tmo_cnt_q     <= '0;
      end else begin
         sync1_q       <= pll_locked;
         lk_s_q        <= sync1_q;
         state_q       <= state_d;
         rst_tmr_q     <= rst_tmr_d;
         lock_tmr_q    <= lock_tmr_d;
         stab_tmr_q    <= stab_tmr_d;
         pll_rst_q     <= pll_rst_d;
         sys_reset_n_q <= sys_reset_n_d;
         lost_cnt_q    <= lost_cnt_d;
         tmo_cnt_q     <= tmo_cnt_d;
      end
   end

   assign pll_rst     = pll_rst_q;
   assign sys_reset_n = sys_reset_n_q;
   assign state       = state_q;
   assign lost_cnt    = lost_cnt_q;
   assign tmo_cnt     = tmo_cnt_q;

endmodule

// File: tb/tb_pll_vdp_supervisor.sv
// tb_pll_vdp_supervisor
// ---------------------
// Drives the supervisor through a table of {inputs, cycles, expected outputs}
// records, then hand-written sequences for counter saturation and the
// asynchronous reset. Expected outputs are queued when stimulus is applied
// and popped when the DUT outputs are sampled, 1 time unit after refclk rises.
module tb_pll_vdp_supervisor;

   localparam int CNT_W = 8;

   logic             refclk = 1'b0;
   logic             rst_n;
   logic             pll_locked;
   logic             relock_req;
   logic             pll_rst;
   logic             sys_reset_n;
   logic [1:0]       state;
   logic [CNT_W-1:0] lost_cnt;
   logic [CNT_W-1:0] tmo_cnt;

   int asserts  = 0;
   int failures = 0;

   typedef struct {
      string      name;
      int         cycles;
      logic       locked;
      logic       relock;
      logic [1:0] exp_state;
      logic       exp_pll_rst;
      logic       exp_sys;
      logic [7:0] exp_lost;
      logic [7:0] exp_tmo;
   } vec_t;

   typedef struct {
      string      name;
      logic [1:0] st;
      logic       pr;
      logic       sr;
      logic [7:0] lo;
      logic [7:0] tm;
   } exp_t;

   vec_t vecs[$];
   exp_t scoreboard[$];

   pll_vdp_supervisor #(
      .RST_CYCLES    (4),
      .LOCK_TIMEOUT  (100),
      .STABLE_CYCLES (8),
      .CNT_W         (CNT_W)
   ) dut (
      .refclk      (refclk),
      .rst_n       (rst_n),
      .pll_locked  (pll_locked),
      .relock_req  (relock_req),
      .pll_rst     (pll_rst),
      .sys_reset_n (sys_reset_n),
      .state       (state),
      .lost_cnt    (lost_cnt),
      .tmo_cnt     (tmo_cnt)
   );

   // 50 MHz-style reference clock, period 10 time units.
   always #5 refclk = ~refclk;

   // Hard stop in case something hangs outside the bounded waits.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation still running, expected to have finished");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic void addVec(string name, int cycles, logic locked, logic relock,
                                  logic [1:0] st, logic pr, logic sr,
                                  logic [7:0] lo, logic [7:0] tm);
      vec_t v;
      v.name = name; v.cycles = cycles; v.locked = locked; v.relock = relock;
      v.exp_state = st; v.exp_pll_rst = pr; v.exp_sys = sr;
      v.exp_lost = lo; v.exp_tmo = tm;
      vecs.push_back(v);
   endfunction

   function automatic void expectNow(string name, logic [1:0] st, logic pr, logic sr,
                                     logic [7:0] lo, logic [7:0] tm);
      exp_t e;
      e.name = name; e.st = st; e.pr = pr; e.sr = sr; e.lo = lo; e.tm = tm;
      scoreboard.push_back(e);
   endfunction

   function automatic void checkField(string vname, string field,
                                      logic [7:0] act, logic [7:0] exp);
      asserts++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s.%s: got %0d, expected %0d", vname, field, act, exp);
      end
   endfunction

   task automatic checkOutput();
      exp_t e;
      if (scoreboard.size() == 0) begin
         asserts++;
         failures++;
         $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
      end else begin
         e = scoreboard.pop_front();
         checkField(e.name, "state",       {6'd0, state},       {6'd0, e.st});
         checkField(e.name, "pll_rst",     {7'd0, pll_rst},     {7'd0, e.pr});
         checkField(e.name, "sys_reset_n", {7'd0, sys_reset_n}, {7'd0, e.sr});
         checkField(e.name, "lost_cnt",    lost_cnt,            e.lo);
         checkField(e.name, "tmo_cnt",     tmo_cnt,             e.tm);
      end
   endtask

   // relock_req is a single-cycle pulse: it is dropped after the first edge.
   task automatic applyStimulus(input vec_t v);
      pll_locked = v.locked;
      relock_req = v.relock;
      expectNow(v.name, v.exp_state, v.exp_pll_rst, v.exp_sys, v.exp_lost, v.exp_tmo);
      for (int i = 0; i < v.cycles; i++) begin
         @(posedge refclk);
         #1;
         relock_req = 1'b0;
      end
      checkOutput();
   endtask

   task automatic waitState(input logic [1:0] s, input int limit, input string name,
                            output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         if (state == s) begin
            ok = 1'b1;
            break;
         end
         @(posedge refclk);
         #1;
      end
      if (!ok && state == s) ok = 1'b1;
      if (!ok) begin
         asserts++;
         failures++;
         $display("[TB] FAIL %s: state %0d after %0d cycles, expected %0d", name, state, limit, s);
      end
   endtask

   initial begin
      bit ok;
      int exp_lost;

      // Edge numbers in comments count refclk edges after rst_n release.
      addVec("rst_hold",       3,   1, 0, 2'd0, 1, 0, 0, 0);  // edge 3
      addVec("wait_entry",     1,   1, 0, 2'd1, 0, 0, 0, 0);  // edge 4
      addVec("stable_entry",   1,   1, 0, 2'd2, 0, 0, 0, 0);  // edge 5
      addVec("stable_last",    7,   1, 0, 2'd2, 0, 0, 0, 0);  // edge 12
      addVec("run_entry",      1,   1, 0, 2'd3, 0, 1, 0, 0);  // edge 13
      addVec("run_hold",       5,   1, 0, 2'd3, 0, 1, 0, 0);  // edge 18
      addVec("loss_sync",      2,   0, 0, 2'd3, 0, 1, 0, 0);  // edge 20
      addVec("loss_edge3",     1,   0, 0, 2'd0, 1, 0, 1, 0);  // edge 21
      addVec("relock_stab",    12,  1, 0, 2'd2, 0, 0, 1, 0);  // edge 33
      addVec("rerun",          1,   1, 0, 2'd3, 0, 1, 1, 0);  // edge 34
      addVec("sw_relock",      1,   1, 1, 2'd0, 1, 0, 1, 0);  // edge 35
      addVec("relock_in_rst",  3,   1, 1, 2'd0, 1, 0, 1, 0);  // edge 38
      addVec("rst_not_ext",    1,   1, 0, 2'd1, 0, 0, 1, 0);  // edge 39
      addVec("stab_after_req", 1,   1, 0, 2'd2, 0, 0, 1, 0);  // edge 40
      addVec("run_after_req",  8,   1, 0, 2'd3, 0, 1, 1, 0);  // edge 48
      addVec("glitch_prep",    1,   1, 1, 2'd0, 1, 0, 1, 0);  // edge 49
      addVec("glitch_wait",    4,   1, 0, 2'd1, 0, 0, 1, 0);  // edge 53
      addVec("glitch_stab5",   6,   1, 0, 2'd2, 0, 0, 1, 0);  // edge 59
      addVec("glitch_caught",  3,   0, 0, 2'd1, 0, 0, 1, 0);  // edge 62
      addVec("glitch_hold",    2,   1, 0, 2'd1, 0, 0, 1, 0);  // edge 64
      addVec("requal_start",   1,   1, 0, 2'd2, 0, 0, 1, 0);  // edge 65
      addVec("requal_full",    7,   1, 0, 2'd2, 0, 0, 1, 0);  // edge 72
      addVec("requal_run",     1,   1, 0, 2'd3, 0, 1, 1, 0);  // edge 73
      addVec("tmo_loss",       3,   0, 0, 2'd0, 1, 0, 2, 0);  // edge 76
      addVec("tmo_wait",       4,   0, 0, 2'd1, 0, 0, 2, 0);  // edge 80
      addVec("tmo_edge_m1",    99,  0, 0, 2'd1, 0, 0, 2, 0);  // edge 179
      addVec("tmo_first",      1,   0, 0, 2'd0, 1, 0, 2, 1);  // edge 180
      addVec("tmo_third",      208, 0, 0, 2'd0, 1, 0, 2, 3);  // edge 388
      addVec("tmo_req_prep",   103, 0, 0, 2'd1, 0, 0, 2, 3);  // edge 491
      addVec("tmo_and_req",    1,   0, 1, 2'd0, 1, 0, 2, 4);  // edge 492

      rst_n      = 1'b0;
      pll_locked = 1'b1;
      relock_req = 1'b0;
      #12;
      expectNow("reset_state", 2'd0, 1'b1, 1'b0, 8'd0, 8'd0);
      checkOutput();

      @(posedge refclk);
      #1;
      rst_n = 1'b1;

      foreach (vecs[i]) applyStimulus(vecs[i]);

      // Repeated lock losses until lost_cnt saturates.
      exp_lost = 2;
      for (int i = 0; i < 260; i++) begin
         pll_locked = 1'b1;
         waitState(2'd3, 40, "sat_reach_run", ok);
         pll_locked = 1'b0;
         waitState(2'd0, 10, "sat_loss", ok);
         exp_lost = (exp_lost < 255) ? exp_lost + 1 : 255;
         expectNow("sat_loss", 2'd0, 1'b1, 1'b0, 8'(exp_lost), 8'd4);
         checkOutput();
      end

      // Asynchronous reset mid-RUN, away from any clock edge.
      pll_locked = 1'b1;
      waitState(2'd3, 40, "async_reach_run", ok);
      expectNow("async_pre", 2'd3, 1'b0, 1'b1, 8'd255, 8'd4);
      checkOutput();
      @(posedge refclk);
      #3;
      rst_n = 1'b0;
      #1;
      expectNow("async_reset", 2'd0, 1'b1, 1'b0, 8'd0, 8'd0);
      checkOutput();
      #10;
      rst_n = 1'b1;
      repeat (3) @(posedge refclk);
      #1;
      expectNow("post_async", 2'd0, 1'b1, 1'b0, 8'd0, 8'd0);
      checkOutput();

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
      $finish;
   end

endmodule
